// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the IM and DM cache sides.
//
// Behaviour summary:
//   - Round-robin grant on conflict between the two sides.
//   - The winner's request is latched onto a req/ack memory interface.
//   - A registered one-cycle valid (with read data) goes back to the granted side.
//   - A per-transaction watchdog aborts with err=1 if mem_ack never arrives.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   im_req/we/addr/wdata -> im_rdata/valid    IM requester
//   dm_req/we/addr/wdata -> dm_rdata/valid    DM requester
//   mem_req/we/addr/wdata, mem_rdata/ack      memory port
//   err                                 high with x_valid when the transaction timed out
//   grant_dm                            current or last grant owner (debug)
module mem_port_arbiter #(
  parameter int unsigned memAddrWidth = 15,
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    im_req,
  input  logic [3:0]              im_we,
  input  logic [memAddrWidth-1:0] im_addr,
  input  logic [31:0]             im_wdata,
  output logic [31:0]             im_rdata,
  output logic                    im_valid,
  input  logic                    dm_req,
  input  logic [3:0]              dm_we,
  input  logic [memAddrWidth-1:0] dm_addr,
  input  logic [31:0]             dm_wdata,
  output logic [31:0]             dm_rdata,
  output logic                    dm_valid,
  output logic                    mem_req,
  output logic [3:0]              mem_we,
  output logic [memAddrWidth-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    err,
  output logic                    grant_dm
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam bit               WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IM = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_dm_q, last_dm_d;
  logic                    grant_dm_q, grant_dm_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic [WE_W-1:0]         mem_we_q, mem_we_d;
  logic [memAddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]       im_rdata_q, im_rdata_d;
  logic [DATA_W-1:0]       dm_rdata_q, dm_rdata_d;
  logic                    im_valid_q, im_valid_d;
  logic                    dm_valid_q, dm_valid_d;
  logic                    err_q, err_d;

  logic                    im_elig, dm_elig, pick_dm;
  logic                    done, done_err;
  logic [DATA_W-1:0]       done_data;

  // State and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b1;
      grant_dm_q  <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      im_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      im_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      grant_dm_q  <= grant_dm_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      im_rdata_q  <= im_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      im_valid_q  <= im_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  // Grant, completion and watchdog decisions
  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    grant_dm_d  = grant_dm_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    im_rdata_d  = im_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    im_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = 1'b0;
    pick_dm     = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = '0;
    // A req still held during its own valid cycle is not a new request
    im_elig     = im_req & ~im_valid_q;
    dm_elig     = dm_req & ~dm_valid_q;

    case (state_q)
      IDLE: begin
        if (im_elig || dm_elig) begin
          // On conflict the side that did not win last time goes first
          pick_dm     = dm_elig && (!im_elig || !last_dm_q);
          state_d     = pick_dm ? BUSY_DM : BUSY_IM;
          last_dm_d   = pick_dm;
          grant_dm_d  = pick_dm;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dm ? dm_we    : im_we;
          mem_addr_d  = pick_dm ? dm_addr  : im_addr;
          mem_wdata_d = pick_dm ? dm_wdata : im_wdata;
        end
      end
      BUSY_IM, BUSY_DM: begin
        if (mem_ack) begin
          done      = 1'b1;
          done_data = (mem_we_q == '0) ? mem_rdata : '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // Abort lands exactly TIMEOUT_CYC cycles after mem_req rose
          if (WD_EN && (cnt_q == TO_LAST)) begin
            done     = 1'b1;
            done_err = 1'b1;
          end
        end
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = done_err;
          if (state_q == BUSY_DM) begin
            dm_valid_d = 1'b1;
            dm_rdata_d = done_data;
          end else begin
            im_valid_d = 1'b1;
            im_rdata_d = done_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign im_rdata  = im_rdata_q;
  assign im_valid  = im_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_req   [2];
  logic [3:0]    s_we    [2];
  logic [AW-1:0] s_addr  [2];
  logic [31:0]   s_wdata [2];
  logic          im_req, dm_req;
  logic [3:0]    im_we, dm_we;
  logic [AW-1:0] im_addr, dm_addr;
  logic [31:0]   im_wdata, dm_wdata, im_rdata, dm_rdata;
  logic          im_valid, dm_valid;
  logic          mem_req, mem_ack, err, grant_dm;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  assign im_req = s_req[0];  assign im_we = s_we[0];  assign im_addr = s_addr[0];  assign im_wdata = s_wdata[0];
  assign dm_req = s_req[1];  assign dm_we = s_we[1];  assign dm_addr = s_addr[1];  assign dm_wdata = s_wdata[1];

  mem_port_arbiter #(.memAddrWidth(AW), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .im_req(im_req), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .im_rdata(im_rdata), .im_valid(im_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .grant_dm(grant_dm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic prev_dut_req = 1'b0;
  bit auto_mode = 1'b0;

  // Transaction-level model: who owns the port, what was latched, how long it has waited
  int            owner;     // -1 idle, 0 IM, 1 DM
  int            elapsed;   // edges without ack since the grant
  bit            last_dm;
  logic          m_req, m_gdm, m_imv, m_dmv, m_err;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_imr, m_dmr;

  // Random requester / memory state
  bit s_done [2];
  int wait_left = 0;
  logic prev_mreq = 1'b0;

  task automatic model_reset();
    owner = -1; elapsed = 0; last_dm = 1'b1;
    m_req = 0; m_gdm = 0; m_imv = 0; m_dmv = 0; m_err = 0;
    m_we = '0; m_addr = '0; m_wdata = '0; m_imr = '0; m_dmr = '0;
  endtask

  task automatic respond(input int side, input logic [31:0] d, input logic e);
    if (side == 0) begin m_imv = 1'b1; m_imr = d; end
    else begin m_dmv = 1'b1; m_dmr = d; end
    m_err = e; m_req = 1'b0; owner = -1;
  endtask

  task automatic model_edge();
    logic pv_im, pv_dm, im_e, dm_e;
    int win;
    pv_im = m_imv; pv_dm = m_dmv;
    m_imv = 1'b0; m_dmv = 1'b0; m_err = 1'b0;
    if (owner >= 0) begin
      if (mem_ack) respond(owner, (m_we != 4'd0) ? 32'd0 : mem_rdata, 1'b0);
      else begin
        elapsed++;
        if (TO != 0 && elapsed >= int'(TO)) respond(owner, 32'd0, 1'b1);
      end
    end else begin
      im_e = im_req && !pv_im;
      dm_e = dm_req && !pv_dm;
      win = -1;
      if (im_e && dm_e) win = last_dm ? 0 : 1;
      else if (im_e)    win = 0;
      else if (dm_e)    win = 1;
      if (win >= 0) begin
        owner = win; elapsed = 0; last_dm = (win == 1); m_gdm = last_dm; m_req = 1'b1;
        m_we = s_we[win]; m_addr = s_addr[win]; m_wdata = s_wdata[win];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic check_all();
    chk("mem_req",   32'(mem_req),   32'(m_req));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("im_valid",  32'(im_valid),  32'(m_imv));
    chk("dm_valid",  32'(dm_valid),  32'(m_dmv));
    chk("err",       32'(err),       32'(m_err));
    chk("grant_dm",  32'(grant_dm),  32'(m_gdm));
    if (m_imv) chk("im_rdata", im_rdata, m_imr);
    if (m_dmv) chk("dm_rdata", dm_rdata, m_dmr);
    if (mem_req && !prev_dut_req) rises++;
    prev_dut_req = mem_req;
  endtask

  task automatic new_req(input int s);
    s_req[s]   = 1'b1;
    s_we[s]    = $urandom_range(1, 0) ? 4'd0 : 4'($urandom_range(15, 1));
    s_addr[s]  = AW'($urandom);
    s_wdata[s] = $urandom;
  endtask

  task automatic drive_random();
    logic v;
    for (int s = 0; s < 2; s++) begin
      v = (s == 0) ? m_imv : m_dmv;
      if (v) s_done[s] = 1'b1;  // keep req high through the valid cycle
      else if (s_done[s]) begin
        s_done[s] = 1'b0;
        if ($urandom_range(1, 0) == 1) s_req[s] = 1'b0;
        else new_req(s);
      end else if (!s_req[s]) begin
        if ($urandom_range(2, 0) == 0) new_req(s);
      end else if ($urandom_range(3, 0) == 0) begin
        s_addr[s]  = AW'($urandom);
        s_wdata[s] = $urandom;
      end
    end
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (m_req && !prev_mreq) wait_left = $urandom_range(6, 0);
    if (m_req) begin
      if (wait_left == 0) mem_ack = 1'b1;
      else wait_left--;
    end else if ($urandom_range(15, 0) == 0) mem_ack = 1'b1;
    prev_mreq = m_req;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
    if (auto_mode) drive_random();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      s_req[s] = 0; s_we[s] = '0; s_addr[s] = '0; s_wdata[s] = '0; s_done[s] = 0;
    end
    mem_ack = 0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_grant_dm", 32'(grant_dm), 32'd0);
    chk("rst_valids", 32'({im_valid, dm_valid, err}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_all();
    rst_n = 1'b1;

    // First conflict after reset goes to IM; DM follows on the edge after im_valid
    s_req[0] = 1; s_we[0] = 4'd0;    s_addr[0] = 15'h0040;
    s_req[1] = 1; s_we[1] = 4'b0011; s_addr[1] = 15'h0200; s_wdata[1] = 32'h1234;
    step();
    chk("c1_grant_im", 32'(grant_dm), 32'd0);
    chk("c1_addr_im", 32'(mem_addr), 32'h0040);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    step();
    mem_ack = 0;
    chk("c1_im_valid", 32'(im_valid), 32'd1);
    chk("c1_im_rdata", im_rdata, 32'hCAFE0001);
    step();
    s_req[0] = 0;
    chk("c1_grant_dm", 32'(grant_dm), 32'd1);
    chk("c1_dm_we", 32'(mem_we), 32'h3);
    chk("c1_dm_wdata", mem_wdata, 32'h1234);
    // Requester inputs change mid-transaction; the latched address must not
    s_addr[1] = 15'h7FFF;
    step();
    chk("busy_addr_hold1", 32'(mem_addr), 32'h0200);
    step();
    chk("busy_addr_hold2", 32'(mem_addr), 32'h0200);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 0;
    chk("c1_dm_valid", 32'(dm_valid), 32'd1);
    chk("c1_write_rdata", dm_rdata, 32'd0);
    step();
    s_req[1] = 0;
    step();

    // IM-only read, ack two cycles after mem_req; req held through the valid cycle
    rises = 0;
    s_req[0] = 1; s_we[0] = 4'd0; s_addr[0] = 15'h0100;
    step();
    chk("rd_addr", 32'(mem_addr), 32'h0100);
    chk("rd_we", 32'(mem_we), 32'd0);
    step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    chk("rd_im_valid", 32'(im_valid), 32'd1);
    chk("rd_im_rdata", im_rdata, 32'hDEADBEEF);
    chk("rd_dm_valid", 32'(dm_valid), 32'd0);
    chk("rd_err", 32'(err), 32'd0);
    step();
    s_req[0] = 0;
    chk("rd_no_regrant", 32'(mem_req), 32'd0);
    step(); step();
    chk("held_req_grants", 32'(rises), 32'd1);

    // Last winner was IM, so the next conflict is served DM first
    s_req[0] = 1; s_addr[0] = 15'h0011;
    s_req[1] = 1; s_we[1] = 4'd0; s_addr[1] = 15'h0022;
    step();
    chk("c2_grant_dm", 32'(grant_dm), 32'd1);
    mem_ack = 1; mem_rdata = 32'h0000_00AA;
    step();
    mem_ack = 0;
    chk("c2_dm_valid", 32'(dm_valid), 32'd1);
    step();
    s_req[1] = 0;
    chk("c2_then_im", 32'(grant_dm), 32'd0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("c2_im_valid", 32'(im_valid), 32'd1);
    step();
    s_req[0] = 0;
    step();

    // Watchdog: no ack, mem_req stays up exactly TO cycles, then err response
    s_req[1] = 1; s_we[1] = 4'd0; s_addr[1] = 15'h0333;
    mem_rdata = 32'h5555AAAA;
    step();
    for (int i = 0; i < int'(TO); i++) begin
      chk("wd_req_high", 32'(mem_req), 32'd1);
      step();
    end
    chk("wd_req_low", 32'(mem_req), 32'd0);
    chk("wd_dm_valid", 32'(dm_valid), 32'd1);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_rdata", dm_rdata, 32'd0);
    step();
    s_req[1] = 0;
    mem_ack = 1;  // late ack, two edges after the abort
    step();
    mem_ack = 0;
    chk("late_ack_valid", 32'({im_valid, dm_valid}), 32'd0);
    step();

    // Asynchronous reset mid-transaction
    s_req[0] = 1; s_we[0] = 4'd0; s_addr[0] = 15'h0055;
    step();
    chk("mid_req_up", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    s_req[0] = 0;
    #1;
    chk("async_req_drop", 32'(mem_req), 32'd0);
    chk("async_valids", 32'({im_valid, dm_valid, err}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_req[0] = 1; s_addr[0] = 15'h0066;
    s_req[1] = 1; s_we[1] = 4'd0; s_addr[1] = 15'h0077;
    step();
    chk("post_rst_grant_im", 32'(grant_dm), 32'd0);
    chk("post_rst_addr", 32'(mem_addr), 32'h0066);

    // Randomized traffic against the model
    auto_mode = 1'b1;
    repeat (3000) step();
    auto_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing-memory port between the instruction-cache side (IM) and the data-cache side (DM) of the RV32 core.
- Accepts word requests from both sides and grants one at a time, with round-robin on conflict.
- Drives a single req/ack memory interface and returns a registered one-cycle valid with read data to the granted side.
- Includes a per-transaction watchdog, so a stuck memory produces an error response instead of stalling the core forever.

Parameters:
- memAddrWidth, 15, address width of both requester ports and the memory port.
- TIMEOUT_CYC, 255, cycles to wait for mem_ack before aborting; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk input 1 system clock, rising edge.
- rst_n input 1 asynchronous, active-low reset.
- im_req input 1 IM request; held high until im_valid is seen.
- im_we input 4 IM byte write mask; 0 means read.
- im_addr input memAddrWidth IM word address.
- im_wdata input 32 IM write data.
- im_rdata output 32 IM read data; meaningful only while im_valid=1.
- im_valid output 1 one-cycle IM completion pulse.
- dm_req, dm_we, dm_addr, dm_wdata, dm_rdata, dm_valid: same widths and meanings as the IM ports, for the DM side.
- mem_req output 1 memory request, held until ack or abort.
- mem_we output 4 latched byte mask.
- mem_addr output memAddrWidth latched address.
- mem_wdata output 32 latched write data.
- mem_rdata input 32 memory read data; valid in the mem_ack cycle.
- mem_ack input 1 memory completion, one-cycle pulse.
- err output 1 high together with x_valid when that transaction timed out.
- grant_dm output 1 current or last grant owner: 0 = IM, 1 = DM (debug).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=DM, counter=0. All outputs are 0, and mem_req drops immediately even mid-transaction. No response is ever delivered for a transaction cut off by reset.
- FSM states: IDLE, BUSY_IM, BUSY_DM.
- Eligibility in IDLE: a side is eligible when x_req=1 and x_valid=0. The x_valid=0 term means the req still held during the x_valid cycle never re-triggers a grant.
- IDLE transitions, evaluated at each clock edge:
  - Only IM eligible -> BUSY_IM.
  - Only DM eligible -> BUSY_DM.
  - Both eligible -> the side != last_grant wins. The first conflict after reset therefore goes to IM.
  - On every grant: last_grant and grant_dm update; mem_addr/mem_we/mem_wdata latch the winner's inputs; mem_req=1 from that edge; counter is cleared.
- BUSY_x, mem_ack=1 at an edge:
  - mem_req <- 0, state -> IDLE.
  - x_rdata <- mem_rdata for reads; for writes (x_we!=0) x_rdata <- 0.
  - x_valid <- 1 for exactly one cycle; err <- 0.
- BUSY_x, mem_ack=0: counter increments.
  - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1, abort: mem_req <- 0, state -> IDLE, x_valid <- 1, err <- 1, x_rdata <- 0.
  - An abort therefore happens exactly TIMEOUT_CYC cycles after mem_req rises.
- mem_ack in IDLE is ignored. A late ack after an abort produces no response.
- Latency:
  - Request sampled at edge N -> mem_req high after N.
  - Ack at edge N+k -> x_valid high for the cycle after N+k.
  - Next grant earliest at edge N+k+1, so back-to-back transactions cost 1 idle edge.
- Requester inputs are not sampled while BUSY. Latched mem_* values stay stable for the whole transaction even if requester inputs change.
- im_valid and dm_valid are never high in the same cycle. err is 0 whenever both valids are 0.
- mem_we/mem_addr/mem_wdata hold their last latched values in IDLE. Only mem_req qualifies them.
- Counter saturates, never wraps. It is cleared on every grant.

Test Plan:
- IM-only read: im_addr=0x0100, im_we=0; memory acks 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x0100, mem_we=0; im_rdata=0xDEADBEEF with im_valid pulse 1 cycle after ack; dm_valid stays 0; err=0.
- Simultaneous first conflict after reset: im_req and dm_req both rise (dm_addr=0x0200, dm_we=4'b0011, dm_wdata=0x1234) -> IM granted first. DM is granted on the edge after im_valid, with mem_we=4'b0011 and mem_wdata=0x1234. A second simultaneous pair is served DM first.
- Input change mid-transaction: in BUSY_DM, change dm_addr from 0x0200 to 0x7FFF -> mem_addr stays 0x0200 until ack.
- Watchdog: TIMEOUT_CYC=4, no ack -> mem_req high exactly 4 cycles, then dm_valid=1 and err=1 for one cycle, dm_rdata=0. A late mem_ack 2 cycles later produces no valid.
- Reset mid-transaction: drop rst_n asynchronously while BUSY_IM -> mem_req and all valids are 0 immediately without a clock. After release, the first conflict grants IM.
- Held req during valid: IM keeps im_req=1 through the im_valid cycle and drops it next -> exactly one grant and one mem_req pulse train.
